hex_marquee_scroller: RTL
=========================

Name: hex_marquee_scroller

Overview:
- Parametrised successor to the switch-selected rotating "HELLO" display.
- Stores an N-character message of 3-bit character codes and scrolls it autonomously across NUM_DIGITS active-low 7-segment displays at a programmable rate.
- Supports scroll direction, pause, and reload.
- Sits between board switches/keys and the HEX outputs of the top-level lab design.

Parameters:
- NUM_DIGITS, 5, number of 7-segment displays driven (>=1)
- MSG_LEN, 8, number of characters in the message buffer (>=1)
- TICK_DIV, 50000000, clock cycles per scroll step (>=1; 1 = step every cycle)

Ports:
- CLOCK_50  input  1  system clock; all state changes on its rising edge
- RESET  input  1  synchronous, active-high reset
- MSG  input  3*MSG_LEN  message; character i at MSG[3i+2:3i]
- LOAD  input  1  capture MSG into the shadow buffer and restart scrolling
- DIR  input  1  0 = scroll left (offset increments), 1 = scroll right (offset decrements)
- PAUSE  input  1  freeze scrolling while high
- HEX  output  7*NUM_DIGITS  digit k at HEX[7k+6:7k]; bit 7k+i = segment i (0=a .. 6=g), active-low; digit NUM_DIGITS-1 is leftmost

Behaviour:
- Character codes: 0=H, 1=E, 2=L, 3=O, 4..7=blank.
- Active-low patterns for segments a..g:
  - H=1001000
  - E=0110000
  - L=1110001
  - O=0000001
  - blank=1111111
- Reset (sync, RESET=1 at edge) clears the following:
  - state=IDLE, offset=0, prescaler=0
  - shadow buffer all 3'd7
  - HEX all ones (blank); this holds from the first edge with RESET=1
- FSM states: IDLE, RUN, PAUSED.
  - IDLE: displays blank; LOAD -> RUN if PAUSE=0, else PAUSED.
  - RUN: PAUSE=1 -> PAUSED.
  - PAUSED: PAUSE=0 -> RUN.
  - LOAD in any state reloads the buffer and selects RUN/PAUSED from PAUSE.
- LOAD:
  - Shadow <= MSG, offset <= 0, prescaler <= 0.
  - MSG is ignored at all other times.
- Prescaler:
  - Runs only in RUN.
  - Counts 0..TICK_DIV-1, then wraps to 0 and asserts an internal one-cycle tick on that edge.
  - Holds its value in PAUSED.
- Offset (width max(1,$clog2(MSG_LEN))):
  - On tick in RUN, DIR=0: offset <= (offset+1) mod MSG_LEN.
  - DIR=1: offset <= (offset+MSG_LEN-1) mod MSG_LEN.
  - DIR is sampled at each tick.
- Display mapping: digit k shows shadow[(offset + NUM_DIGITS-1-k) mod MSG_LEN].
  - The modulo is exact for any NUM_DIGITS, including NUM_DIGITS > MSG_LEN, where the message repeats.
- HEX is registered and reflects state/offset/shadow one cycle after they change.
- Latencies:
  - LOAD at edge t: new message visible from edge t+1.
  - First scroll step at edge t+TICK_DIV; visible at t+TICK_DIV+1.
- Priority: RESET > LOAD > tick. A LOAD coincident with a tick discards the tick.
- MSG_LEN=1: offset is constant 0; all digits show character 0.
- Reset mid-scroll: immediate return to IDLE/blank; no partial state is retained.

Optional Feature:
- Macro: HEX_MARQUEE_BOUNCE_EN.
- Defined:
  - An internal direction register replaces wrap-around scrolling; it is initialised from DIR at LOAD.
  - Forward: reaching offset == MSG_LEN-NUM_DIGITS causes the next tick to toggle direction and decrement.
  - Backward: reaching offset 0 causes the next tick to toggle direction and increment.
  - DIR is ignored between LOADs.
  - If MSG_LEN <= NUM_DIGITS, offset stays 0.
- Undefined: modulo wrap as specified above; DIR is live.

Decomposition:
- Package marquee_pkg holds:
  - CHAR_W=3, SEG_W=7
  - Character code constants CH_H, CH_E, CH_L, CH_O, CH_BLANK(=7)
  - Segment pattern constants SEG_H, SEG_E, SEG_L, SEG_O, SEG_BLANK
  - Enum for FSM states (IDLE, RUN, PAUSED)
- Sub-module: hex_char_decode, a combinational 3-bit code -> 7-bit active-low pattern decoder, instantiated NUM_DIGITS times via generate.
- Output registers live in the parent.

Test Plan (NUM_DIGITS=5, MSG_LEN=8, TICK_DIV=4, MSG="HELLO   " = codes 0,1,2,2,3,7,7,7):
- Reset then idle 10 cycles -> all HEX digits 1111111; FSM in IDLE.
- LOAD pulse at edge t, PAUSE=0, DIR=0 -> at t+1, digits 4..0 = H,E,L,L,O. At t+5 they = E,L,L,O,blank. After 8 steps (t+33) the display returns to H,E,L,L,O.
- DIR=1 after LOAD -> first step shows blank,H,E,L,L; the next shows blank,blank,H,E,L.
- PAUSE=1 for 10 cycles mid-scroll -> HEX frozen and prescaler held. After release, the next step occurs after the remaining prescaler count, not a full TICK_DIV.
- LOAD asserted on the same edge as a tick, with new MSG = all code 3 -> offset 0 and all digits O at the next cycle; no step applied.
- RESET asserted mid-scroll -> HEX blank at the next cycle. A subsequent tick-aligned period with no LOAD leaves the display blank.
- With HEX_MARQUEE_BOUNCE_EN: offset sequence after LOAD is 0,1,2,3,2,1,0,1.

Source files
------------

// File: rtl/marquee_pkg.sv
// ============================================================================
//  Package     : marquee_pkg
//  Description : Shared widths, character codes, active-low 7-segment
//                patterns and FSM state type for the hex marquee scroller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package marquee_pkg;

    localparam int CHAR_W = 3;
    localparam int SEG_W  = 7;

    // Character codes; 4..7 all render blank, 7 is the canonical blank
    localparam logic [CHAR_W-1:0] CH_H     = 3'd0;
    localparam logic [CHAR_W-1:0] CH_E     = 3'd1;
    localparam logic [CHAR_W-1:0] CH_L     = 3'd2;
    localparam logic [CHAR_W-1:0] CH_O     = 3'd3;
    localparam logic [CHAR_W-1:0] CH_BLANK = 3'd7;

    // Active-low segment patterns, bit i = segment i (bit 0 = a .. bit 6 = g)
    localparam logic [SEG_W-1:0] SEG_H     = 7'b0001001;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_L     = 7'b1000111;
    localparam logic [SEG_W-1:0] SEG_O     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/hex_char_decode.sv
// ============================================================================
//  Module      : hex_char_decode
//  Description : Combinational 3-bit character code to active-low 7-segment
//                pattern decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_char_decode
    import marquee_pkg::*;
(
    input  logic [CHAR_W-1:0] code,
    output logic [SEG_W-1:0]  seg
);

    // Code-to-pattern lookup; every unused code is blank
    always_comb begin
        seg = SEG_BLANK;
        case (code)
            CH_H:    seg = SEG_H;
            CH_E:    seg = SEG_E;
            CH_L:    seg = SEG_L;
            CH_O:    seg = SEG_O;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/hex_marquee_scroller.sv
// ============================================================================
//  Module      : hex_marquee_scroller
//  Description : Scrolls an MSG_LEN-character message across NUM_DIGITS
//                active-low 7-segment displays at one step per TICK_DIV
//                clocks, with direction, pause and reload control.
//  Options     : define HEX_MARQUEE_BOUNCE_EN for back-and-forth scrolling
//                (direction latched at LOAD) instead of modulo wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_marquee_scroller
    import marquee_pkg::*;
#(
    parameter int NUM_DIGITS = 5,
    parameter int MSG_LEN    = 8,
    parameter int TICK_DIV   = 50000000
) (
    input  logic                      CLOCK_50,
    input  logic                      RESET,
    input  logic [CHAR_W*MSG_LEN-1:0] MSG,
    input  logic                      LOAD,
    input  logic                      DIR,
    input  logic                      PAUSE,
    output logic [SEG_W*NUM_DIGITS-1:0] HEX
);

    localparam int OFF_W = (MSG_LEN  > 1) ? $clog2(MSG_LEN)  : 1;
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t                           state;
    state_t                           next_state;
    logic [OFF_W-1:0]                 offset;
    logic [OFF_W-1:0]                 step_offset;
    logic [PRE_W-1:0]                 prescaler;
    logic [MSG_LEN-1:0][CHAR_W-1:0]   shadow;
    logic [NUM_DIGITS-1:0][SEG_W-1:0] seg_all;
    logic                             tick;

    // The tick fires on the edge where the prescaler wraps, only while running
    assign tick = (state == RUN) && (prescaler == PRE_W'(TICK_DIV - 1));

    // FSM state register
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state; LOAD overrides the state-specific transitions
    always_comb begin
        next_state = state;
        if (LOAD) begin
            next_state = PAUSE ? PAUSED : RUN;
        end else begin
            case (state)
                RUN:     if (PAUSE)  next_state = PAUSED;
                PAUSED:  if (!PAUSE) next_state = RUN;
                default: next_state = state;
            endcase
        end
    end

    // Prescaler: restarts on LOAD, counts only while running, holds otherwise
    always_ff @(posedge CLOCK_50) begin
        if (RESET || LOAD) begin
            prescaler <= '0;
        end else if (state == RUN) begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
        end
    end

    // Shadow message buffer, written only on LOAD
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            shadow <= {MSG_LEN{CH_BLANK}};
        end else if (LOAD) begin
            shadow <= MSG;
        end
    end

`ifdef HEX_MARQUEE_BOUNCE_EN
    // Highest offset that still keeps every digit inside the message
    localparam int LAST = (MSG_LEN > NUM_DIGITS) ? (MSG_LEN - NUM_DIGITS) : 0;

    logic backward;
    logic next_backward;

    // Bounce step: turn around at either end instead of wrapping
    always_comb begin
        step_offset   = offset;
        next_backward = backward;
        if (MSG_LEN > NUM_DIGITS) begin
            if (!backward) begin
                if (offset == OFF_W'(LAST)) begin
                    next_backward = 1'b1;
                    step_offset   = offset - 1'b1;
                end else begin
                    step_offset   = offset + 1'b1;
                end
            end else begin
                if (offset == '0) begin
                    next_backward = 1'b0;
                    step_offset   = offset + 1'b1;
                end else begin
                    step_offset   = offset - 1'b1;
                end
            end
        end
    end

    // Internal direction, seeded from DIR at LOAD and flipped at the ends
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            backward <= 1'b0;
        end else if (LOAD) begin
            backward <= DIR;
        end else if (tick) begin
            backward <= next_backward;
        end
    end
`else
    // Wrap-around step in the live DIR direction
    always_comb begin
        step_offset = offset;
        if (DIR) begin
            step_offset = (offset == '0) ? OFF_W'(MSG_LEN - 1) : offset - 1'b1;
        end else begin
            step_offset = (offset == OFF_W'(MSG_LEN - 1)) ? '0 : offset + 1'b1;
        end
    end
`endif

    // Scroll offset: cleared on LOAD, advanced on each tick
    always_ff @(posedge CLOCK_50) begin
        if (RESET || LOAD) begin
            offset <= '0;
        end else if (tick) begin
            offset <= step_offset;
        end
    end

    // Per-digit character select and decode; leftmost digit shows shadow[offset]
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        localparam int DIST = (NUM_DIGITS - 1 - k) % MSG_LEN;

        logic [OFF_W:0]    sum;
        logic [OFF_W-1:0]  idx;
        logic [CHAR_W-1:0] code;

        assign sum  = {1'b0, offset} + (OFF_W+1)'(DIST);
        assign idx  = (sum >= (OFF_W+1)'(MSG_LEN)) ? OFF_W'(sum - (OFF_W+1)'(MSG_LEN))
                                                   : OFF_W'(sum);
        assign code = shadow[idx];

        hex_char_decode u_decode (
            .code (code),
            .seg  (seg_all[k])
        );
    end

    // Registered display; blank in reset and while idle
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            HEX <= '1;
        end else if (state == IDLE) begin
            HEX <= '1;
        end else begin
            HEX <= seg_all;
        end
    end

endmodule

`default_nettype wire
